// File: rtl/seq_alu.sv
// seq_alu: registered ALU; single-cycle arithmetic/logic/jumps plus bit-serial
// shifts/rotates and shift-add multiply. Flags CF/ZF/SF/OF are held internally.
// state | meaning
// IDLE  | accepts start, completes single-cycle ops in place
// RUN   | steps a shift/rotate or MUL one bit per edge, cnt_q counts down to 1
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SH_W-1:0]  im,
  input  logic [WIDTH-1:0] im8,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             jmp,
  output logic             CF,
  output logic             ZF,
  output logic             SF,
  output logic             OF
);
  localparam int M = WIDTH - 1;
  localparam int CNT_W = SH_W + 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [4:0] OP_ADD = 5'b00001, OP_AND = 5'b00010, OP_SUB = 5'b00011,
                         OP_OR  = 5'b00100, OP_XOR = 5'b00101, OP_MOV = 5'b00110,
                         OP_ADC = 5'b00111, OP_NOT = 5'b01000, OP_SAR = 5'b01001,
                         OP_SHR = 5'b01010, OP_SAL = 5'b01011, OP_SHL = 5'b01100,
                         OP_ROL = 5'b01101, OP_ROR = 5'b01110, OP_INC = 5'b01111,
                         OP_DEC = 5'b10000, OP_MUL = 5'b10001, OP_CMP = 5'b10110,
                         OP_JE  = 5'b11000, OP_JB  = 5'b11001, OP_JA  = 5'b11010,
                         OP_JL  = 5'b11011, OP_JG  = 5'b11100, OP_JMP = 5'b11101,
                         OP_LI  = 5'b11110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d, acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         op_q, op_d;
  logic               cf_q, cf_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic               done_q, done_d, jmp_q, jmp_d, msb_q, msb_d;

  logic [WIDTH:0]     sum_w, mul_sum;
  logic [WIDTH-1:0]   opb, r, shifted;
  logic [2*WIDTH-1:0] prod_next;
  logic               bit_out, upd_zs;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    msb_d   = msb_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    done_d  = 1'b0;
    jmp_d   = 1'b0;
    sum_w   = '0;
    opb     = '0;
    r       = '0;
    upd_zs  = 1'b0;

    // One step of the multiply: conditionally add multiplicand to the high half, shift right.
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, acc_q} : '0);
    prod_next = {mul_sum, prod_q[WIDTH-1:1]};

    case (op_q)
      OP_SAR:  begin shifted = {acc_q[M], acc_q[M:1]}; bit_out = acc_q[0]; end
      OP_SHR:  begin shifted = {1'b0, acc_q[M:1]};     bit_out = acc_q[0]; end
      OP_ROL:  begin shifted = {acc_q[M-1:0], acc_q[M]}; bit_out = acc_q[M]; end
      OP_ROR:  begin shifted = {acc_q[0], acc_q[M:1]}; bit_out = acc_q[0]; end
      default: begin shifted = {acc_q[M-1:0], 1'b0};   bit_out = acc_q[M]; end
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          done_d = 1'b1;
          case (op)
            OP_ADD, OP_ADC, OP_INC: begin
              opb    = (op == OP_INC) ? ONE : in2;
              sum_w  = {1'b0, in1} + {1'b0, opb} + {{WIDTH{1'b0}}, (op == OP_ADC) & cf_q};
              r      = sum_w[M:0];
              res_d  = r;
              cf_d   = sum_w[WIDTH];
              of_d   = (in1[M] == opb[M]) && (r[M] != in1[M]);
              upd_zs = 1'b1;
            end
            OP_SUB, OP_CMP, OP_DEC: begin
              opb    = (op == OP_DEC) ? ONE : in2;
              sum_w  = {1'b0, in1} - {1'b0, opb};
              r      = sum_w[M:0];
              if (op != OP_CMP) res_d = r;
              cf_d   = sum_w[WIDTH];
              of_d   = (in1[M] != opb[M]) && (r[M] != in1[M]);
              upd_zs = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
              r      = (op == OP_AND) ? (in1 & in2) : (op == OP_OR) ? (in1 | in2) : (in1 ^ in2);
              res_d  = r;
              cf_d   = 1'b0;
              of_d   = 1'b0;
              upd_zs = 1'b1;
            end
            OP_MOV: res_d = in2;
            OP_NOT: res_d = ~in1;
            OP_LI:  res_d = im8;
            OP_SAR, OP_SHR, OP_SAL, OP_SHL, OP_ROL, OP_ROR: begin
              if (im == '0) begin
                res_d = in1;
              end else begin
                state_d = RUN;
                done_d  = 1'b0;
                acc_d   = in1;
                msb_d   = in1[M];
                cnt_d   = {1'b0, im};
                op_d    = op;
              end
            end
            OP_MUL: begin
              state_d = RUN;
              done_d  = 1'b0;
              acc_d   = in1;
              prod_d  = {{WIDTH{1'b0}}, in2};
              cnt_d   = CNT_W'(WIDTH);
              op_d    = op;
            end
            OP_JE, OP_JB, OP_JA, OP_JL, OP_JG, OP_JMP: begin
              res_d = im8;
              case (op)
                OP_JE:   jmp_d = zf_q;
                OP_JB:   jmp_d = cf_q;
                OP_JA:   jmp_d = !cf_q && !zf_q;
                OP_JL:   jmp_d = sf_q != of_q;
                OP_JG:   jmp_d = !zf_q && (sf_q == of_q);
                default: jmp_d = 1'b1;
              endcase
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == OP_MUL) begin
          prod_d = prod_next;
          if (cnt_q == CNT_W'(1)) begin
            r      = prod_next[M:0];
            res_d  = r;
            cf_d   = |prod_next[2*WIDTH-1:WIDTH];
            of_d   = |prod_next[2*WIDTH-1:WIDTH];
            upd_zs = 1'b1;
          end
        end else begin
          acc_d = shifted;
          if (cnt_q == CNT_W'(1)) begin
            r      = shifted;
            res_d  = r;
            cf_d   = bit_out;
            of_d   = (op_q == OP_SAR || op_q == OP_SHR) ? 1'b0 : (msb_q != shifted[M]);
            upd_zs = 1'b1;
          end
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (upd_zs) begin
      zf_d = (r == '0);
      sf_d = r[M];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      msb_q   <= 1'b0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
      done_q  <= 1'b0;
      jmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      msb_q   <= msb_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
      done_q  <= done_d;
      jmp_q   <= jmp_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign res  = res_q;
  assign jmp  = jmp_q;
  assign CF   = cf_q;
  assign ZF   = zf_q;
  assign SF   = sf_q;
  assign OF   = of_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with hand-computed results for seq_alu at WIDTH=8.
// Flags are compared as the nibble {CF,ZF,SF,OF}.
module tb_seq_alu;
  logic       clock = 1'b0;
  logic       reset, start;
  logic [4:0] op;
  logic [7:0] in1, in2, im8, res;
  logic [2:0] im;
  logic       busy, done, jmp, CF, ZF, SF, OF;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int done_seen;

  localparam logic [4:0] ADD = 5'b00001, SUB = 5'b00011, XOR = 5'b00101, ADC = 5'b00111,
                         SAR = 5'b01001, SHR = 5'b01010, ROL = 5'b01101, INC = 5'b01111,
                         DEC = 5'b10000, MUL = 5'b10001, CMP = 5'b10110, JB  = 5'b11001,
                         JA  = 5'b11010, JL  = 5'b11011, NOP = 5'b10010;

  seq_alu #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .im(im), .im8(im8), .busy(busy), .done(done), .res(res), .jmp(jmp),
    .CF(CF), .ZF(ZF), .SF(SF), .OF(OF)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sh, input logic [7:0] imm);
    op = o; in1 = a; in2 = b; im = sh; im8 = imm; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Cycles from the start edge to the edge that raised done, bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0; im = '0; im8 = '0;
    tick(); tick();
    reset = 1'b0;
    check_eq("rst_res", res, 8'h00);
    check_eq("rst_flags", {CF, ZF, SF, OF}, 4'b0000);
    check_eq("rst_busy_done_jmp", {busy, done, jmp}, 3'b000);

    issue(ADD, 8'h7F, 8'h01, 3'd0, 8'h00);
    check_eq("add_done", done, 1'b1);
    check_eq("add_res", res, 8'h80);
    check_eq("add_flags", {CF, ZF, SF, OF}, 4'b0011);
    tick();
    check_eq("add_done_pulse", done, 1'b0);

    issue(SUB, 8'h05, 8'h07, 3'd0, 8'h00);
    check_eq("sub_res", res, 8'hFE);
    check_eq("sub_flags", {CF, ZF, SF, OF}, 4'b1010);

    issue(JB, 8'h00, 8'h00, 3'd0, 8'h3C);
    check_eq("jb_res", res, 8'h3C);
    check_eq("jb_jmp", jmp, 1'b1);
    check_eq("jb_flags", {CF, ZF, SF, OF}, 4'b1010);
    tick();
    check_eq("jmp_idle", {jmp, done}, 2'b00);

    issue(JA, 8'h00, 8'h00, 3'd0, 8'h55);
    check_eq("ja_res", res, 8'h55);
    check_eq("ja_jmp_done", {jmp, done}, 2'b01);

    issue(ADC, 8'h01, 8'h01, 3'd0, 8'h00);
    check_eq("adc_cin_res", res, 8'h03);
    check_eq("adc_cin_flags", {CF, ZF, SF, OF}, 4'b0000);

    issue(CMP, 8'h10, 8'h20, 3'd0, 8'h00);
    check_eq("cmp_res_kept", res, 8'h03);
    check_eq("cmp_flags", {CF, ZF, SF, OF}, 4'b1010);

    issue(JL, 8'h00, 8'h00, 3'd0, 8'hAA);
    check_eq("jl_res_jmp", {res, jmp}, {8'hAA, 1'b1});

    issue(INC, 8'hFF, 8'h00, 3'd0, 8'h00);
    check_eq("inc_res", res, 8'h00);
    check_eq("inc_flags", {CF, ZF, SF, OF}, 4'b1100);

    issue(DEC, 8'h80, 8'h00, 3'd0, 8'h00);
    check_eq("dec_res", res, 8'h7F);
    check_eq("dec_flags", {CF, ZF, SF, OF}, 4'b0001);

    issue(XOR, 8'hF0, 8'h3C, 3'd0, 8'h00);
    check_eq("xor_res", res, 8'hCC);
    check_eq("xor_flags", {CF, ZF, SF, OF}, 4'b0010);

    issue(NOP, 8'h11, 8'h22, 3'd0, 8'h33);
    check_eq("nop_done", done, 1'b1);
    check_eq("nop_res_flags", {res, CF, ZF, SF, OF}, {8'hCC, 4'b0010});

    // SAR with starts held high while busy; they must be dropped.
    issue(SAR, 8'h90, 8'h00, 3'd3, 8'h00);
    check_eq("sar_busy_e0", {busy, done}, 2'b10);
    op = ADD; in1 = 8'h01; in2 = 8'h01; start = 1'b1;
    tick();
    check_eq("sar_busy_e1", {busy, done}, 2'b10);
    tick();
    check_eq("sar_busy_e2", {busy, done}, 2'b10);
    tick();
    check_eq("sar_done_e3", {busy, done}, 2'b01);
    check_eq("sar_res", res, 8'hF2);
    check_eq("sar_flags", {CF, ZF, SF, OF}, 4'b0010);
    start = 1'b0;
    tick();
    check_eq("sar_ignored_start", {done, res}, {1'b0, 8'hF2});

    issue(ROL, 8'h81, 8'h00, 3'd1, 8'h00);
    wait_done(lat);
    check_eq("rol1_latency", lat, 2);
    check_eq("rol1_res", res, 8'h03);
    check_eq("rol1_flags", {CF, ZF, SF, OF}, 4'b1001);

    issue(ROL, 8'h5A, 8'h00, 3'd0, 8'h00);
    check_eq("rol0_done_busy", {done, busy}, 2'b10);
    check_eq("rol0_res_flags", {res, CF, ZF, SF, OF}, {8'h5A, 4'b1001});

    issue(SHR, 8'h06, 8'h00, 3'd2, 8'h00);
    wait_done(lat);
    check_eq("shr_latency", lat, 3);
    check_eq("shr_res_flags", {res, CF, ZF, SF, OF}, {8'h01, 4'b1000});

    issue(MUL, 8'h10, 8'h20, 3'd0, 8'h00);
    wait_done(lat);
    check_eq("mul_latency", lat, 9);
    check_eq("mul_big_res", res, 8'h00);
    check_eq("mul_big_flags", {CF, ZF, SF, OF}, 4'b1101);

    issue(MUL, 8'h03, 8'h05, 3'd0, 8'h00);
    wait_done(lat);
    check_eq("mul_small_res_flags", {res, CF, ZF, SF, OF}, {8'h0F, 4'b0000});

    issue(SUB, 8'h05, 8'h07, 3'd0, 8'h00);
    issue(MUL, 8'h07, 8'h09, 3'd0, 8'h00);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy_done", {busy, done}, 2'b00);
    check_eq("abort_res_flags", {res, CF, ZF, SF, OF}, {8'h00, 4'b0000});
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) done_seen++;
    end
    check_eq("abort_no_done", done_seen, 0);

    issue(ADC, 8'hFF, 8'h00, 3'd0, 8'h00);
    check_eq("adc_res", res, 8'hFF);
    check_eq("adc_flags", {CF, ZF, SF, OF}, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
